// File: rtl/lbp_pkg.sv
// Shared types and constants for the gray-image read arbiter.
// Image address/data widths, arbiter state encoding, index-width helper.
package lbp_pkg;

  localparam int IMG_AW = 14;
  localparam int PIX_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    OWN  = 2'd2
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gray_rd_arbiter_rr_pick.sv
// Round-robin picker: first asserted request after ptr, with wrap-around.
// Purely combinational.
module rr_pick
  import lbp_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int OW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    ptr,
  output logic [OW-1:0]    winner,
  output logic             any_req
);

  int idx;

  // Descending scan so the nearest index after ptr is written last.
  always_comb begin
    winner  = '0;
    any_req = |req;
    idx     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[OW'(idx)]) winner = OW'(idx);
    end
  end

endmodule

// File: rtl/gray_rd_arbiter.sv
// Round-robin arbiter sharing the gray-image read port with owner-tagged returns.
// Optional ARB_STARVE_GUARD_EN: cap locked bursts at MAX_HOLD beats under contention.
module gray_rd_arbiter
  import lbp_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    gray_ready,
  output logic                    gray_req,
  output logic [IMG_AW-1:0]       gray_addr,
  input  logic [PIX_DW-1:0]       gray_data,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*IMG_AW-1:0] addr,
  input  logic [N_REQ-1:0]        lock,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic [PIX_DW-1:0]       rdata,
  output logic                    busy
);

  localparam int OW = clog2(N_REQ);

  arb_state_t     state;
  logic [OW-1:0]  owner;
  logic [OW-1:0]  ptr;
  logic [OW-1:0]  winner;
  logic           any_req;
  logic           own;
  logic           guard_rel;

  logic [RD_LAT-1:0] pv;
  logic [OW-1:0]     po [RD_LAT];

  rr_pick #(.N_REQ(N_REQ), .OW(OW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign own      = (state == OWN);
  assign gray_req = own & req[owner];
  assign rdata    = gray_data;
  assign busy     = (state != IDLE) | (|pv);

  always_comb begin
    gray_addr = '0;
    if (own)
      for (int i = 0; i < N_REQ; i++)
        if (owner == OW'(i))
          gray_addr = addr[i*IMG_AW +: IMG_AW];
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int HW = clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_cnt;
  logic          other_req;

  assign other_req = |(req & ~gnt);
  assign guard_rel = gray_req & (hold_cnt == HOLD_LAST) & other_req;

  // Saturates so a long uncontended burst still yields on the next contended beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      hold_cnt <= '0;
    else if (state == ARB)
      hold_cnt <= '0;
    else if (gray_req && hold_cnt != HOLD_LAST)
      hold_cnt <= hold_cnt + 1'b1;
  end
`else
  assign guard_rel = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= OW'(N_REQ - 1);
    end else if (!gray_ready) begin
      state <= IDLE;
      gnt   <= '0;
    end else begin
      unique case (state)
        IDLE: state <= ARB;
        ARB: if (any_req) begin
          gnt   <= N_REQ'(1) << winner;
          owner <= winner;
          state <= OWN;
        end
        OWN: if (!lock[owner] || guard_rel) begin
          gnt   <= '0;
          ptr   <= owner;
          state <= ARB;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return tags travel with each beat; losing gray_ready discards them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        po[i] <= '0;
      end
    end else if (!gray_ready) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        po[i] <= '0;
      end
    end else begin
      pv[0] <= gray_req;
      po[0] <= owner;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        po[i] <= po[i-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < N_REQ; i++)
      rvalid[i] = pv[RD_LAT-1] & (po[RD_LAT-1] == OW'(i));
  end

endmodule

// File: tb/tb_gray_rd_arbiter.sv
// Randomized bench for gray_rd_arbiter against a transaction-level model.
// Directed scenarios pin grant order, bursts, flush and async reset.
module tb_gray_rd_arbiter;

  localparam int N        = 2;
  localparam int RD_LAT   = 2;
  localparam int MAX_HOLD = 4;
  localparam int AW       = 14;

  logic            clk = 0;
  logic            reset = 0;
  logic            gray_ready = 0;
  logic            gray_req;
  logic [AW-1:0]   gray_addr;
  logic [7:0]      gray_data;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N-1:0]    lock = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [7:0]      rdata;
  logic            busy;

  gray_rd_arbiter #(.N_REQ(N), .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .req        (req),
    .addr       (addr),
    .lock       (lock),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [AW-1:0] a);
    return 8'(a ^ (a >> 6)) ^ 8'h5A;
  endfunction

  // Image memory with RD_LAT cycles of read latency.
  logic [7:0] dq [RD_LAT];
  always @(posedge clk) begin
    dq[0] <= gray_req ? memf(gray_addr) : 8'h00;
    for (int i = 1; i < RD_LAT; i++) dq[i] <= dq[i-1];
  end
  assign gray_data = dq[RD_LAT-1];

  int total = 0;
  int bad = 0;
  int cyc_n = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_n, act, exp);
    end
  endtask

  typedef struct {
    int         due;
    int         who;
    logic [7:0] data;
  } beat_t;

  beat_t q[$];
  bit    m_up;
  int    m_owner;
  int    m_ptr;
  int    m_hold;

  task automatic model_reset();
    q.delete();
    m_up    = 0;
    m_owner = -1;
    m_ptr   = N - 1;
    m_hold  = 0;
  endtask

  function automatic logic [AW-1:0] slice(input int i);
    return addr[i*AW +: AW];
  endfunction

  task automatic compare();
    logic [N-1:0]  e_gnt, e_rv;
    logic          e_req, e_busy;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_data;
    e_gnt = '0; e_rv = '0; e_req = 0; e_busy = 0; e_addr = '0; e_data = 0;
    if (reset) begin
      if (m_owner >= 0) begin
        e_gnt  = N'(1) << m_owner;
        e_req  = req[m_owner];
        e_addr = slice(m_owner);
      end
      if (q.size() > 0 && q[0].due == cyc_n) begin
        e_rv   = N'(1) << q[0].who;
        e_data = q[0].data;
      end
      e_busy = m_up || (q.size() > 0);
    end
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("gray_req", 32'(gray_req), 32'(e_req));
    chk("gray_addr", 32'(gray_addr), 32'(e_addr));
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    chk("busy", 32'(busy), 32'(e_busy));
    if (e_rv != 0) chk("rdata", 32'(rdata), 32'(e_data));
  endtask

  // Advance the model across the coming rising edge.
  task automatic step();
    bit beat, rel;
    if (q.size() > 0 && q[0].due == cyc_n) void'(q.pop_front());
    if (!gray_ready) begin
      q.delete();
      m_up    = 0;
      m_owner = -1;
    end else if (!m_up) begin
      m_up = 1;
    end else if (m_owner < 0) begin
      for (int k = N; k >= 1; k--)
        if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_hold = 0;
    end else begin
      beat = req[m_owner];
      if (beat)
        q.push_back('{cyc_n + RD_LAT, m_owner, memf(slice(m_owner))});
      rel = !lock[m_owner];
`ifdef ARB_STARVE_GUARD_EN
      if (beat && m_hold >= MAX_HOLD - 1 && (req & ~(N'(1) << m_owner)) != 0)
        rel = 1;
      if (beat) m_hold++;
`endif
      if (rel) begin
        m_ptr   = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic cyc(input logic gr, input logic [N-1:0] rq,
                     input logic [N-1:0] lk, input logic [AW-1:0] a0,
                     input logic [AW-1:0] a1);
    @(posedge clk);
    cyc_n++;
    #1;
    gray_ready = gr;
    req        = rq;
    lock       = lk;
    addr       = {a1, a0};
    @(negedge clk);
    compare();
    step();
  endtask

  task automatic do_reset();
    @(posedge clk);
    cyc_n++;
    #1;
    reset      = 0;
    gray_ready = 0;
    req        = '0;
    lock       = '0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_req", 32'(gray_req), 0);
    chk("rst_addr", 32'(gray_addr), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    compare();
    reset = 1;
    model_reset();
    step();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1, '0, '0, 14'h0, 14'h0);
  endtask

  logic [N-1:0]  seq_g [6];
  logic [AW-1:0] a3;
  int n0, n1, first1;
  bit seen1, seen_g1;

  initial begin
    model_reset();
    do_reset();
    do_reset();

    // Single beat from requester 0.
    cyc(1, 2'b01, 2'b00, 14'h0081, 14'h0);
    chk("t1_idle_gnt", 32'(gnt), 0);
    cyc(1, 2'b01, 2'b00, 14'h0081, 14'h0);
    chk("t1_arb_gnt", 32'(gnt), 0);
    cyc(1, 2'b01, 2'b00, 14'h0081, 14'h0);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_req", 32'(gray_req), 1);
    chk("t1_addr", 32'(gray_addr), 32'h0081);
    cyc(1, 2'b00, 2'b00, 14'h0081, 14'h0);
    chk("t1_rv_early", 32'(rvalid), 0);
    cyc(1, 2'b00, 2'b00, 14'h0081, 14'h0);
    chk("t1_rv", 32'(rvalid), 32'h1);
    chk("t1_rdata", 32'(rdata), 32'(memf(14'h0081)));
    drain(2);

    // Continuous contention, no lock: strict alternation from ptr=0.
    seq_g = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    for (int i = 0; i < 6; i++) begin
      cyc(1, 2'b11, 2'b00, 14'h0123, 14'h0456);
      chk("t2_gnt_seq", 32'(gnt), 32'(seq_g[i]));
      if (i == 1) chk("t2_addr1", 32'(gray_addr), 32'h0456);
      if (i == 3) chk("t2_addr0", 32'(gray_addr), 32'h0123);
    end
    drain(4);

    // 3x3 locked burst by requester 0 while requester 1 waits.
    n0 = 0; seen1 = 0;
    cyc(1, 2'b01, 2'b01, 14'h0204, 14'h0777);
    for (int b = 0; b < 9; b++) begin
      a3 = {7'(4 + b / 3 - 1), 7'(4 + b % 3 - 1)};
      cyc(1, 2'b11, 2'b01, a3, 14'h0777);
      chk("t3_hold", 32'(gnt), 32'h1);
      if (rvalid[0]) n0++;
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1, 2'b10, 2'b00, 14'h0, 14'h0777);
      if (rvalid[0]) n0++;
      if (rvalid[1] && !seen1) begin
        seen1 = 1;
        chk("t3_order", 32'(n0), 9);
      end
    end
    chk("t3_seen1", 32'(seen1), 1);
    drain(4);

    // gray_ready drops mid-burst with beats in flight.
    cyc(1, 2'b01, 2'b01, 14'h0300, 14'h0);
    cyc(1, 2'b01, 2'b01, 14'h0301, 14'h0);
    cyc(1, 2'b01, 2'b01, 14'h0302, 14'h0);
    cyc(0, 2'b01, 2'b01, 14'h0303, 14'h0);
    cyc(0, 2'b00, 2'b00, 14'h0, 14'h0);
    chk("t4_gnt", 32'(gnt), 0);
    chk("t4_req", 32'(gray_req), 0);
    chk("t4_rv", 32'(rvalid), 0);
    cyc(0, 2'b00, 2'b00, 14'h0, 14'h0);
    chk("t4_busy", 32'(busy), 0);
    drain(3);

    // Async reset mid-ownership, then first grant goes to requester 0.
    cyc(1, 2'b01, 2'b01, 14'h0400, 14'h0);
    cyc(1, 2'b01, 2'b01, 14'h0401, 14'h0);
    do_reset();
    cyc(1, 2'b11, 2'b00, 14'h0500, 14'h0600);
    cyc(1, 2'b11, 2'b00, 14'h0500, 14'h0600);
    cyc(1, 2'b11, 2'b00, 14'h0500, 14'h0600);
    chk("t5_first_gnt", 32'(gnt), 32'h1);
    drain(4);

`ifdef ARB_STARVE_GUARD_EN
    n1 = 0; seen_g1 = 0;
    cyc(1, 2'b01, 2'b01, 14'h0700, 14'h0701);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 2'b11, 2'b01, 14'h0700, 14'h0701);
      if (gnt == 2'b01 && gray_req && !seen_g1) n1++;
      if (gnt == 2'b10) seen_g1 = 1;
    end
    chk("t6_beats", 32'(n1), 4);
    chk("t6_handover", 32'(seen_g1), 1);
    drain(4);
`endif

    // Randomized traffic.
    first1 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 39) != 0),
            N'($urandom_range(0, 3)),
            N'($urandom_range(0, 3) & $urandom_range(0, 3)),
            AW'($urandom), AW'($urandom));
      end
    end
    drain(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
